// File: rtl/time_set_key_ctrl_if.sv
// Button/time bus between the board-side driver and the time-setting controller.
// The master drives keys, enable, preload; the slave returns the committed time.
interface time_set_key_ctrl_if;
  logic        en;
  logic        load;
  logic        key_in_p;
  logic        key_in_n;
  logic        key_in_e;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_out_vld;

  modport master (
    output en,
    output load,
    output key_in_p,
    output key_in_n,
    output key_in_e,
    output data_in,
    input  data_out,
    input  data_out_vld
  );

  modport slave (
    input  en,
    input  load,
    input  key_in_p,
    input  key_in_n,
    input  key_in_e,
    input  data_in,
    output data_out,
    output data_out_vld
  );
endinterface

// File: rtl/time_set_key_ctrl.sv
// Three-button BCD HH:MM editor: debounced plus/next/enter keys edit a preloaded
// working time, and enter publishes it with a one-cycle valid strobe.
module time_set_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic                 clk,
  input logic                 rst,
  time_set_key_ctrl_if.slave  bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  // Key index: 0 = plus, 1 = next, 2 = enter
  localparam int KEY_P = 0;
  localparam int KEY_N = 1;
  localparam int KEY_E = 2;

  typedef enum logic {
    SEL_MIN  = 1'b0,
    SEL_HOUR = 1'b1
  } sel_t;

  // Two-digit BCD increment with wrap; out-of-range or non-BCD input restarts at 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v >= max_v)) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [2:0]    key_raw_s;
  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    level_r;
  logic [2:0]    evt_r;
  logic [CW-1:0] cnt_r [3];

  sel_t          sel_r;
  sel_t          sel_s;
  logic [15:0]   work_r;
  logic [15:0]   work_s;
  logic [15:0]   data_out_r;
  logic [15:0]   data_out_s;
  logic          vld_r;
  logic          vld_s;

  assign key_raw_s = {bus.key_in_e, bus.key_in_n, bus.key_in_p};

  // Synchronize, debounce and detect presses (accepted 1->0) on all three keys
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      level_r <= 3'b111;
      evt_r   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r <= key_raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
          evt_r[i] <= 1'b0;
        end else if (cnt_r[i] == CNT_LAST) begin
          cnt_r[i]   <= CNT_ZERO;
          level_r[i] <= sync2_r[i];
          evt_r[i]   <= ~sync2_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
          evt_r[i] <= 1'b0;
        end
      end
    end
  end

  // Edit/commit state register
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r      <= SEL_MIN;
      work_r     <= 16'h0000;
      data_out_r <= 16'h0000;
      vld_r      <= 1'b0;
    end else begin
      sel_r      <= sel_s;
      work_r     <= work_s;
      data_out_r <= data_out_s;
      vld_r      <= vld_s;
    end
  end

  // One action per cycle: load beats any key; among keys enter > next > plus
  always_comb begin
    sel_s      = sel_r;
    work_s     = work_r;
    data_out_s = data_out_r;
    vld_s      = 1'b0;
    if (bus.load) begin
      work_s = bus.data_in;
      sel_s  = SEL_MIN;
    end else if (bus.en) begin
      if (evt_r[KEY_E]) begin
        data_out_s = work_r;
        vld_s      = 1'b1;
      end else if (evt_r[KEY_N]) begin
        sel_s = (sel_r == SEL_MIN) ? SEL_HOUR : SEL_MIN;
      end else if (evt_r[KEY_P]) begin
        case (sel_r)
          SEL_MIN:  work_s[7:0]  = bcd_inc(work_r[7:0], 8'h59);
          SEL_HOUR: work_s[15:8] = bcd_inc(work_r[15:8], 8'h23);
          default:  work_s       = work_r;
        endcase
      end else begin
        work_s = work_r;
      end
    end else begin
      work_s = work_r;
    end
  end

  assign bus.data_out     = data_out_r;
  assign bus.data_out_vld = vld_r;

endmodule

// File: tb/tb_time_set_key_ctrl.sv
// Randomized bench for time_set_key_ctrl against a transaction-level model of
// the HH:MM editor (decimal arithmetic on the fields, counted valid strobes).
module tb_time_set_key_ctrl;

  localparam int DB = 8;

  logic clk;
  logic rst;
  time_set_key_ctrl_if bus ();

  time_set_key_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int vld_seen;

  // Reference model state
  logic [15:0] m_work;
  logic [15:0] m_out;
  bit          m_hour;
  int          m_vld;

  always @(negedge clk) begin
    if (bus.data_out_vld === 1'b1) vld_seen++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_inc(input logic [7:0] v, input int maxv);
    int t;
    int u;
    int val;
    t = int'(v[7:4]);
    u = int'(v[3:0]);
    if (t > 9 || u > 9) return 8'h00;
    val = t * 10 + u;
    if (val >= maxv) return 8'h00;
    val = val + 1;
    return {4'(val / 10), 4'(val % 10)};
  endfunction

  task automatic model_key(input logic [2:0] mask);
    if (bus.load === 1'b1 || bus.en !== 1'b1) return;
    if (mask[2]) begin
      m_out = m_work;
      m_vld++;
    end else if (mask[1]) begin
      m_hour = !m_hour;
    end else if (mask[0]) begin
      if (m_hour) m_work[15:8] = model_inc(m_work[15:8], 23);
      else        m_work[7:0]  = model_inc(m_work[7:0], 59);
    end
  endtask

  task automatic set_keys(input logic [2:0] mask, input logic lvl);
    if (mask[0]) bus.key_in_p = lvl;
    if (mask[1]) bus.key_in_n = lvl;
    if (mask[2]) bus.key_in_e = lvl;
  endtask

  // Bursts of lvl separated by the opposite level, each shorter than the debounce window
  task automatic bounce(input logic [2:0] mask, input logic lvl);
    int nb;
    nb = $urandom_range(0, 3);
    for (int b = 0; b < nb; b++) begin
      set_keys(mask, lvl);
      cycles($urandom_range(1, DB - 2));
      set_keys(mask, ~lvl);
      cycles($urandom_range(1, DB - 2));
    end
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    bounce(mask, 1'b0);
    set_keys(mask, 1'b0);
    cycles(hold);
    bounce(mask, 1'b1);
    set_keys(mask, 1'b1);
    cycles(DB + 6);
    model_key(mask);
  endtask

  task automatic press_r(input logic [2:0] mask);
    press(mask, $urandom_range(DB + 4, 3 * DB));
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.data_in = v;
    bus.load    = 1'b1;
    cycles(2);
    bus.load    = 1'b0;
    bus.data_in = 16'($urandom);
    m_work = v;
    m_hour = 1'b0;
    cycles(1);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_vld_cnt"}, vld_seen, m_vld);
    check({tag, "_data"}, bus.data_out, m_out);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vld_seen = 0;
    m_work = 16'h0000;
    m_out  = 16'h0000;
    m_hour = 1'b0;
    m_vld  = 0;
    bus.en = 1'b1;
    bus.load = 1'b0;
    bus.key_in_p = 1'b1;
    bus.key_in_n = 1'b1;
    bus.key_in_e = 1'b1;
    bus.data_in  = 16'h0000;
    rst = 1'b1;
    cycles(5);
    rst = 1'b0;
    cycles(2);
    check("rst_data", bus.data_out, 16'h0000);
    check("rst_vld", bus.data_out_vld, 1'b0);

    // Preload and single edit
    do_load(16'h1223);
    press_r(3'b001);
    press_r(3'b001);
    check_state("tp1_pre_e");
    press_r(3'b100);
    check_state("tp1");
    check("tp1_const", bus.data_out, 16'h1225);

    // Field switch
    do_load(16'h1223);
    press_r(3'b001); press_r(3'b001); press_r(3'b010);
    press_r(3'b001); press_r(3'b001);
    check_state("tp2_pre_e");
    press_r(3'b100);
    check_state("tp2");
    check("tp2_const", bus.data_out, 16'h1425);

    // Wraps and invalid BCD
    do_load(16'h2359); press_r(3'b001); press_r(3'b100);
    check("wrap_min", bus.data_out, 16'h2300);
    do_load(16'h2359); press_r(3'b010); press_r(3'b001); press_r(3'b100);
    check("wrap_hour", bus.data_out, 16'h0059);
    do_load(16'h1A3F); press_r(3'b001); press_r(3'b100);
    check("bad_bcd", bus.data_out, 16'h1A00);
    check_state("wraps");

    // Bounce-only activity produces nothing
    do_load(16'h0815);
    bounce(3'b101, 1'b0);
    set_keys(3'b101, 1'b1);
    cycles(DB + 6);
    check_state("bounce_only");

    // Long hold gives exactly one increment
    press(3'b001, 5 * DB);
    press_r(3'b100);
    check("long_hold", bus.data_out, 16'h0816);
    check_state("long_hold");

    // Disabled keys are discarded
    bus.en = 1'b0;
    press_r(3'b001);
    press_r(3'b100);
    check_state("en_off");
    bus.en = 1'b1;
    press_r(3'b100);
    check_state("en_on");

    // Load held across a plus event drops the increment
    bus.data_in = 16'h0930;
    bus.load = 1'b1;
    press_r(3'b001);
    bus.load = 1'b0;
    m_work = 16'h0930;
    m_hour = 1'b0;
    press_r(3'b100);
    check("load_prio", bus.data_out, 16'h0930);
    check_state("load_prio");

    // Simultaneous events: enter beats plus, next beats plus
    press_r(3'b101);
    check_state("e_over_p");
    press_r(3'b011);
    press_r(3'b001);
    press_r(3'b100);
    check("n_over_p", bus.data_out, 16'h1030);
    check_state("n_over_p");

    // Reset mid-edit and mid-debounce
    do_load(16'h1111);
    press_r(3'b001);
    set_keys(3'b001, 1'b0);
    cycles(DB / 2);
    rst = 1'b1;
    cycles(1);
    set_keys(3'b001, 1'b1);
    cycles(3);
    rst = 1'b0;
    m_work = 16'h0000; m_hour = 1'b0; m_out = 16'h0000;
    cycles(DB + 6);
    check_state("mid_rst");
    press_r(3'b100);
    check_state("post_rst_e");

    // Randomized operations
    for (int k = 0; k < 110; k++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0: do_load(($urandom_range(0, 3) == 0) ? 16'($urandom) :
                   {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))});
        1: bus.en = ($urandom_range(0, 3) != 0);
        2, 3: press_r(3'b010);
        4, 5, 6: press_r(3'b001);
        7, 8: press_r(3'b100);
        default: begin
          bounce(3'b111, 1'b0);
          set_keys(3'b111, 1'b1);
          cycles(DB + 6);
        end
      endcase
      if (k % 5 == 4) check_state("rand");
    end
    bus.en = 1'b1;
    press_r(3'b100);
    check_state("rand_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
